// File: rtl/npc_fetch_ctrl_pkg.sv
// Shared constants for the fetch stage: FSM encoding, bubble
// instruction and sequential PC increment.
package fetch_pkg;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/npc_fetch_ctrl_if.sv
// Fetch-stage bus: memory read, hazard/redirect controls and the
// IF/ID outputs presented to decode.
interface npc_fetch_ctrl_if;
    import fetch_pkg::*;

    logic [31:0] instr_in;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic [1:0]  fstate;

    modport master (
        input  instr_in, stall, br_taken, br_target,
        output pc_out, npc_out, if_id_instr, if_id_npc,
        output if_id_valid, fetch_count, fstate
    );

    modport slave (
        output instr_in, stall, br_taken, br_target,
        input  pc_out, npc_out, if_id_instr, if_id_npc,
        input  if_id_valid, fetch_count, fstate
    );

endinterface

// File: rtl/npc_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline latch: clear-to-bubble beats hold, hold beats load.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        hold,
    input  logic [31:0] instr,
    input  logic [31:0] npc,
    output logic [31:0] instr_q,
    output logic [31:0] npc_q,
    output logic        valid_q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            instr_q <= NOP_INSTR;
            npc_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (!hold) begin
            instr_q <= instr;
            npc_q   <= npc;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/npc_fetch_ctrl.sv
// Fetch sequencer: PC register, next-PC mux, fetch FSM and
// accepted-instruction counter feeding the IF/ID latch.
module npc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    npc_fetch_ctrl_if.master   bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_inc;
    logic [31:0] target;
    logic [31:0] npc;
    logic [31:0] count_q;
    logic [1:0]  fstate_q;
    logic        fetch;

    assign pc_inc = pc_q + PC_INC;
    assign target = bus.br_target & ~32'h3;
    assign fetch  = !bus.br_taken && !bus.stall;

    always_comb begin
        npc = pc_q;
        unique case (1'b1)
            bus.br_taken: npc = target;
            !bus.stall:   npc = pc_inc;
            default:      npc = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= 32'h0;
            fstate_q <= FLUSH;
        end else begin
            pc_q <= npc;
            if (bus.br_taken)
                fstate_q <= FLUSH;
            else if (bus.stall)
                fstate_q <= STALL;
            else
                fstate_q <= RUN;
            if (fetch)
                count_q <= count_q + 32'd1;
        end
    end

    // Reset and redirect both squash the latch to a bubble.
    if_id_reg u_if_id (
        .clk     (clk),
        .clear   (rst || bus.br_taken),
        .hold    (bus.stall),
        .instr   (bus.instr_in),
        .npc     (pc_inc),
        .instr_q (bus.if_id_instr),
        .npc_q   (bus.if_id_npc),
        .valid_q (bus.if_id_valid)
    );

    assign bus.pc_out      = pc_q;
    assign bus.npc_out     = npc;
    assign bus.fetch_count = count_q;
    assign bus.fstate      = fstate_q;

endmodule

// File: tb/tb_npc_fetch_ctrl.sv
// Scoreboard bench for npc_fetch_ctrl: expected IF/ID entries are
// queued when a fetch is driven and popped when they reach decode.
module tb_npc_fetch_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    npc_fetch_ctrl_if bus ();
    npc_fetch_ctrl_if bus2 ();

    npc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    npc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.master)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h2008_0005;
        return 32'hA500_0000 ^ (a * 32'd3);
    endfunction

    assign bus.instr_in  = mem(bus.pc_out);
    assign bus2.instr_in = mem(bus2.pc_out);

    exp_t        sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic pop(output exp_t e);
        if (sb.size() == 0) begin
            e.instr = 32'hx;
            e.npc   = 32'hx;
        end else begin
            e = sb.pop_front();
        end
    endtask

    // Apply one cycle of inputs and advance the reference PC model.
    task automatic drive(input logic s, input logic b,
                         input logic [31:0] t);
        bus.stall     = s;
        bus.br_taken  = b;
        bus.br_target = t;
        @(posedge clk);
        if (b) begin
            m_pc = t & ~32'h3;
        end else if (!s) begin
            sb.push_back('{instr: mem(m_pc), npc: m_pc + 32'd4});
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        bus.stall    = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc  = 32'h0;
        m_cnt = 32'h0;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        bus.stall    = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (bus.pc_out !== 32'h0)
            $display("FAIL reset_pc got=%h exp=%h", bus.pc_out, 32'h0);
        else n_pass++;
        n_total++;
        if (bus.if_id_valid !== 1'b0)
            $display("FAIL reset_valid got=%b exp=0", bus.if_id_valid);
        else n_pass++;
        n_total++;
        if (bus.fetch_count !== 32'h0)
            $display("FAIL reset_count got=%h exp=0", bus.fetch_count);
        else n_pass++;
        n_total++;
        if (bus.fstate !== 2'd2)
            $display("FAIL reset_fstate got=%0d exp=2", bus.fstate);
        else n_pass++;
        rst = 1'b0;
        m_pc = 32'h0;
        m_cnt = 32'h0;
        sb.delete();
        drive(1'b0, 1'b0, 32'h0);
        pop(e);
        n_total++;
        if (bus.if_id_instr !== 32'h2008_0005 || e.instr !== 32'h2008_0005)
            $display("FAIL first_instr got=%h exp=%h",
                     bus.if_id_instr, 32'h2008_0005);
        else n_pass++;
        n_total++;
        if (bus.if_id_npc !== e.npc || bus.pc_out !== 32'h4)
            $display("FAIL first_npc npc=%h pc=%h exp npc=%h pc=4",
                     bus.if_id_npc, bus.pc_out, e.npc);
        else n_pass++;
        n_total++;
        if (bus.if_id_valid !== 1'b1)
            $display("FAIL first_valid got=%b exp=1", bus.if_id_valid);
        else n_pass++;
    endtask

    task automatic test_sequential();
        exp_t e;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            pop(e);
            n_total++;
            if (bus.pc_out !== 32'(4 * i) ||
                bus.if_id_instr !== e.instr ||
                bus.if_id_npc !== e.npc)
                $display("FAIL seq_%0d pc=%h instr=%h npc=%h exp pc=%h instr=%h npc=%h",
                         i, bus.pc_out, bus.if_id_instr, bus.if_id_npc,
                         32'(4 * i), e.instr, e.npc);
            else n_pass++;
        end
        n_total++;
        if (bus.fetch_count !== 32'd5)
            $display("FAIL seq_count got=%0d exp=5", bus.fetch_count);
        else n_pass++;
    endtask

    task automatic test_stall();
        exp_t e;
        logic [31:0] held_instr;
        logic [31:0] held_npc;
        do_reset();
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        void'(sb.pop_front());
        pop(e);
        held_instr = e.instr;
        held_npc   = e.npc;
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1;
            #1;
            n_total++;
            if (bus.npc_out !== 32'h8)
                $display("FAIL stall_npc_%0d got=%h exp=8", i, bus.npc_out);
            else n_pass++;
            drive(1'b1, 1'b0, 32'h0);
            n_total++;
            if (bus.pc_out !== 32'h8 || bus.if_id_instr !== held_instr ||
                bus.if_id_npc !== held_npc || bus.fstate !== 2'd1)
                $display("FAIL stall_hold_%0d pc=%h instr=%h npc=%h st=%0d exp pc=8 instr=%h npc=%h st=1",
                         i, bus.pc_out, bus.if_id_instr, bus.if_id_npc,
                         bus.fstate, held_instr, held_npc);
            else n_pass++;
        end
        drive(1'b0, 1'b0, 32'h0);
        pop(e);
        n_total++;
        if (bus.if_id_instr !== e.instr || e.instr !== mem(32'h8) ||
            bus.if_id_npc !== 32'hC || bus.fetch_count !== 32'd3)
            $display("FAIL stall_release instr=%h npc=%h cnt=%0d exp instr=%h npc=c cnt=3",
                     bus.if_id_instr, bus.if_id_npc, bus.fetch_count, mem(32'h8));
        else n_pass++;
        drive(1'b0, 1'b0, 32'h0);
        pop(e);
        n_total++;
        if (bus.if_id_npc !== 32'h10 || bus.if_id_instr !== e.instr)
            $display("FAIL stall_nodup npc=%h instr=%h exp npc=10 instr=%h",
                     bus.if_id_npc, bus.if_id_instr, e.instr);
        else n_pass++;
    endtask

    task automatic test_redirect();
        exp_t e;
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        bus.stall     = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0043;
        #1;
        n_total++;
        if (bus.npc_out !== 32'h40)
            $display("FAIL redir_npc got=%h exp=40", bus.npc_out);
        else n_pass++;
        drive(1'b1, 1'b1, 32'h0000_0043);
        n_total++;
        if (bus.pc_out !== 32'h40 || bus.if_id_valid !== 1'b0 ||
            bus.if_id_instr !== 32'h0 || bus.if_id_npc !== 32'h0 ||
            bus.fstate !== 2'd2)
            $display("FAIL redir_bubble pc=%h v=%b instr=%h npc=%h st=%0d exp pc=40 v=0 instr=0 npc=0 st=2",
                     bus.pc_out, bus.if_id_valid, bus.if_id_instr,
                     bus.if_id_npc, bus.fstate);
        else n_pass++;
        n_total++;
        if (bus.fetch_count !== cnt0)
            $display("FAIL redir_count got=%0d exp=%0d", bus.fetch_count, cnt0);
        else n_pass++;
        drive(1'b0, 1'b0, 32'h0);
        pop(e);
        n_total++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_instr !== e.instr ||
            e.instr !== mem(32'h40) || bus.if_id_npc !== 32'h44 ||
            bus.fetch_count !== cnt0 + 32'd1)
            $display("FAIL redir_target v=%b instr=%h npc=%h cnt=%0d exp v=1 instr=%h npc=44 cnt=%0d",
                     bus.if_id_valid, bus.if_id_instr, bus.if_id_npc,
                     bus.fetch_count, mem(32'h40), cnt0 + 32'd1);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bus2.stall     = 1'b0;
        bus2.br_taken  = 1'b0;
        bus2.br_target = 32'h0;
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (bus2.pc_out !== 32'hFFFF_FFFC)
            $display("FAIL wrap_reset_pc got=%h exp=fffffffc", bus2.pc_out);
        else n_pass++;
        rst2 = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (bus2.pc_out !== 32'h0 || bus2.if_id_npc !== 32'h0 ||
            bus2.if_id_instr !== mem(32'hFFFF_FFFC) ||
            bus2.if_id_valid !== 1'b1)
            $display("FAIL wrap pc=%h npc=%h instr=%h v=%b exp pc=0 npc=0 instr=%h v=1",
                     bus2.pc_out, bus2.if_id_npc, bus2.if_id_instr,
                     bus2.if_id_valid, mem(32'hFFFF_FFFC));
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (3) drive(1'b0, 1'b0, 32'h0);
        bus.stall     = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0100;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        n_total++;
        if (bus.pc_out !== 32'h0 || bus.if_id_instr !== 32'h0 ||
            bus.if_id_npc !== 32'h0 || bus.if_id_valid !== 1'b0 ||
            bus.fetch_count !== 32'h0 || bus.fstate !== 2'd2)
            $display("FAIL mid_reset pc=%h instr=%h npc=%h v=%b cnt=%0d st=%0d exp all 0 st=2",
                     bus.pc_out, bus.if_id_instr, bus.if_id_npc,
                     bus.if_id_valid, bus.fetch_count, bus.fstate);
        else n_pass++;
        rst = 1'b0;
        bus.stall    = 1'b0;
        bus.br_taken = 1'b0;
    endtask

    initial begin
        bus.stall      = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = 32'h0;
        bus2.stall     = 1'b0;
        bus2.br_taken  = 1'b0;
        bus2.br_target = 32'h0;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/npc_fetch_ctrl.md
# npc_fetch_ctrl

Fetch-stage sequencer that produces the next-PC value driven into the PC register and captures the fetched instruction into the IF/ID pipeline latch. It owns the fetch program counter and PC+4 arithmetic, applies stall and branch-redirect requests, and presents a valid-qualified instruction and NPC to decode. It sits between instruction memory (combinational read at `pc_out`) and the decode stage.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_in`  in  32  instruction memory read data for address `pc_out`, same cycle.
- `stall`  in  1  hazard-unit hold request.
- `br_taken`  in  1  redirect request from execute.
- `br_target`  in  32  redirect address; bits [1:0] are ignored and treated as 0.
- `pc_out`  out  32  current fetch address.
- `npc_out`  out  32  combinational next fetch address, sent to the PC register input.
- `if_id_instr`  out  32  latched instruction.
- `if_id_npc`  out  32  latched PC+4 of the latched instruction.
- `if_id_valid`  out  1  latch holds a real instruction; 0 means bubble.
- `fetch_count`  out  32  number of instructions accepted into IF/ID, wrapping.

## Operation
- `npc_out` is `{br_target[31:2],2'b00}` when `br_taken`, else `pc_out + 4` when `stall`=0, else `pc_out`.
- PC+4 is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- State register `fstate` has three states: RUN, STALL, FLUSH. Next state is chosen with priority `rst` > `br_taken` > `stall` > normal.
- **rst:**
  - `pc_out`=RESET_PC, `if_id_instr`=NOP (32'h0), `if_id_npc`=0, `if_id_valid`=0, `fetch_count`=0, `fstate`=FLUSH.
  - This applies mid-operation regardless of other inputs.
- **br_taken** (overrides `stall`):
  - `pc_out` <= aligned target.
  - IF/ID <= NOP with `if_id_npc`=0 and valid=0.
  - `fetch_count` unchanged.
  - `fstate` <= FLUSH.
- **stall** (no `br_taken`):
  - `pc_out` and all IF/ID fields hold.
  - `fetch_count` holds.
  - `fstate` <= STALL.
- **Normal:**
  - `pc_out` <= `pc_out`+4.
  - `if_id_instr` <= `instr_in`, `if_id_npc` <= `pc_out`+4, `if_id_valid` <= 1.
  - `fetch_count` <= `fetch_count`+1.
  - `fstate` <= RUN.
- Leaving STALL or FLUSH needs no extra cycle: the first non-stall, non-branch cycle performs a normal fetch.

## Timing
- Instruction at address A (`pc_out`=A in cycle n) appears on `if_id_instr` with valid=1 in cycle n+1, provided there is no stall or redirect at edge n.
- Redirect costs exactly one bubble:
  - `br_taken` sampled at edge n gives `if_id_valid`=0 in cycle n+1 and `pc_out`=target in cycle n+1.
  - The target instruction is valid in IF/ID in cycle n+2.
- First valid instruction after reset deassertion appears one cycle after the first normal edge.
- A stall of k cycles delays every later output by exactly k cycles, with no loss or duplication of instructions.
- `npc_out` is purely combinational from `pc_out`, `stall`, `br_taken` and `br_target`; it does not depend on `instr_in`.

## Structure
- Shared package `fetch_pkg` holds:
  - the `fstate` encoding (RUN=2'd0, STALL=2'd1, FLUSH=2'd2);
  - `NOP_INSTR`=32'h0000_0000;
  - `PC_INC`=4.
- One sub-module is natural: `if_id_reg`, the IF/ID latch with hold (stall) and clear-to-bubble (flush/reset) controls. It holds the instruction, NPC and valid fields.
- Top level keeps the PC register, next-PC mux, state register and counter.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `RESET_PC`=0.
  - During reset: `pc_out`=0, `if_id_valid`=0, `fetch_count`=0.
  - After release, with memory returning 32'h2008_0005 at address 0: next cycle `if_id_instr`=32'h2008_0005, `if_id_npc`=4, `pc_out`=4.
- **Sequential:** 5 normal cycles from 0.
  - `pc_out` steps 4, 8, 12, 16, 20.
  - `fetch_count`=5; `if_id_npc` tracks PC+4.
- **Stall:** `stall`=1 for 3 cycles while `pc_out`=8.
  - `pc_out` and IF/ID are frozen for 3 cycles and `npc_out`=8.
  - After release, the instruction at 8 enters IF/ID exactly once.
- **Redirect:** `br_taken`=1, `br_target`=32'h0000_0043, with `stall`=1 asserted in the same cycle.
  - Next cycle: `pc_out`=32'h40 and `if_id_valid`=0.
  - Following cycle: the instruction at 0x40 is valid and `fetch_count` is unchanged across the bubble.
- **Wrap-around:** `RESET_PC`=32'hFFFF_FFFC, one normal cycle.
  - `pc_out`=0 and `if_id_npc`=0.
- **Mid-operation reset:** `rst` asserted during a stall with `br_taken`=1.
  - All outputs return to their reset values on the next edge.
